tamagotchi_btn_conditioner: RTL and testbench

//  Front end between the board push-buttons and tamagotchi_fsm. Synchronises and debounces
//  six raw active-low keys, emits the one-cycle btn_* pulses the FSM consumes, and runs the

---
 rtl/tamagotchi_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/tamagotchi_btn_conditioner.sv | 199 +++++++++++++++++++
 tb/tb_tamagotchi_btn_conditioner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi button front end: key indices,
// hold-FSM state encoding and helpers that turn ms/s into clock cycles.
package tamagotchi_pkg;

  localparam int NUM_KEYS  = 6;
  localparam int NUM_NEED  = 4;

  // Key indices; the four need keys occupy the low indices
  localparam int SALUD     = 0;
  localparam int ENERGIA   = 1;
  localparam int HAMBRE    = 2;
  localparam int DIVERSION = 3;
  localparam int RESET     = 4;
  localparam int TEST      = 5;

  typedef enum logic [1:0] {
    HOLD_IDLE    = 2'd0,
    HOLD_HOLDING = 2'd1,
    HOLD_FIRED   = 2'd2
  } hold_state_e;

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int s_to_cyc(input int clk_hz, input int s);
    return clk_hz * s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw active-low key: 2-FF synchroniser, debounce counter and a
// one-cycle pulse on the accepted released->pressed transition.
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int            CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pressed_q, pressed_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced level disagrees with the accepted level
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    cnt_d     = '0;
    if ((~sync2_q) != pressed_q) begin
      if (cnt_q == CNT_LAST) begin
        pressed_d = ~sync2_q;
        pulse_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; synchroniser resets to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/tamagotchi_btn_conditioner.sv
// Button front end for tamagotchi_fsm: six debounced keys, masked need-key
// pulses and the reset/test long-press timers.
// Optional feature: define BTN_AUTOREPEAT_EN to re-pulse held need keys
// every REPEAT_MS; without it each debounced press gives exactly one pulse.
module tamagotchi_btn_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_S      = 5,
  parameter int REPEAT_MS   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_salud_n,
  input  logic       key_energia_n,
  input  logic       key_hambre_n,
  input  logic       key_diversion_n,
  input  logic       key_reset_n,
  input  logic       key_test_n,
  output logic       btn_salud,
  output logic       btn_energia,
  output logic       btn_hambre,
  output logic       btn_diversion,
  output logic       btn_reset,
  output logic       btn_test,
  output logic [2:0] count_reset,
  output logic [2:0] count_test
);

  localparam int            DEB_CYC    = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int            SEC_CYC    = s_to_cyc(CLK_HZ, 1);
  localparam int            PW         = $clog2(SEC_CYC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_CYC - 1);
  localparam logic [2:0]    HOLD_CNT   = 3'(HOLD_S);

  // Reject configurations the 3-bit counts or the timers cannot represent
  if (HOLD_S < 1 || HOLD_S > 7) begin : g_bad_hold
    $error("HOLD_S must be in 1..7");
  end
  if (DEBOUNCE_MS < 1 || REPEAT_MS < 1) begin : g_bad_timing
    $error("DEBOUNCE_MS and REPEAT_MS must be at least 1");
  end

  logic [NUM_KEYS-1:0] key_n_vec;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] press_pulse;

  assign key_n_vec = {key_test_n, key_reset_n, key_diversion_n,
                      key_hambre_n, key_energia_n, key_salud_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n_vec[k]),
      .pressed    (pressed[k]),
      .press_pulse(press_pulse[k])
    );
  end

  // Hold FSMs work on debounced levels, so the edge pulses of those keys are not needed
  logic hold_pulse_unused;
  assign hold_pulse_unused = ^press_pulse[TEST:RESET];

  logic [NUM_NEED-1:0] rep_fire;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int            RW       = $clog2(REP_CYC + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_CYC);

  logic [RW-1:0] rep_cnt_q [NUM_NEED];
  logic [RW-1:0] rep_cnt_d [NUM_NEED];

  // Cycles since the last pulse of each held need key; fires every REP_CYC
  always_comb begin
    rep_fire = '0;
    for (int k = 0; k < NUM_NEED; k++) begin
      rep_fire[k]  = pressed[k] && (rep_cnt_q[k] == REP_LAST);
      rep_cnt_d[k] = '0;
      if (pressed[k]) begin
        if (press_pulse[k] || rep_fire[k]) rep_cnt_d[k] = RW'(1);
        else                               rep_cnt_d[k] = rep_cnt_q[k] + RW'(1);
      end
    end
  end

  // Repeat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEED; k++) rep_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_NEED; k++) rep_cnt_q[k] <= rep_cnt_d[k];
    end
  end
`else
  assign rep_fire = '0;
`endif

  logic                need_mask;
  logic [NUM_NEED-1:0] btn_q, btn_d;

  // Need-key pulses are suppressed while either long-press key is held
  always_comb begin
    need_mask = pressed[RESET] | pressed[TEST];
    btn_d     = (press_pulse[NUM_NEED-1:0] | rep_fire) & {NUM_NEED{~need_mask}};
  end

  // Need-key output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn_d;
  end

  // Index 0 is the reset-key timer, index 1 the test-key timer
  hold_state_e   hold_st_q [2];
  hold_state_e   hold_st_d [2];
  logic [PW-1:0] presc_q   [2];
  logic [PW-1:0] presc_d   [2];
  logic [2:0]    cnt_q     [2];
  logic [2:0]    cnt_d     [2];
  logic [1:0]    fire_q, fire_d;
  logic [1:0]    hold_act;

  // Long-press timers; the reset key holds the test timer in IDLE
  always_comb begin
    hold_act[0] = pressed[RESET];
    hold_act[1] = pressed[TEST] & ~pressed[RESET];
    fire_d      = '0;
    for (int i = 0; i < 2; i++) begin
      hold_st_d[i] = hold_st_q[i];
      presc_d[i]   = presc_q[i];
      cnt_d[i]     = cnt_q[i];
      if (!hold_act[i]) begin
        hold_st_d[i] = HOLD_IDLE;
        presc_d[i]   = '0;
        cnt_d[i]     = '0;
      end else begin
        case (hold_st_q[i])
          HOLD_IDLE: begin
            hold_st_d[i] = HOLD_HOLDING;
            presc_d[i]   = '0;
            cnt_d[i]     = '0;
          end
          HOLD_HOLDING: begin
            if (presc_q[i] == PRESC_LAST) begin
              presc_d[i] = '0;
              cnt_d[i]   = cnt_q[i] + 3'd1;
              if (cnt_q[i] + 3'd1 == HOLD_CNT) begin
                fire_d[i]    = 1'b1;
                hold_st_d[i] = HOLD_FIRED;
              end
            end else begin
              presc_d[i] = presc_q[i] + PW'(1);
            end
          end
          HOLD_FIRED: begin
            hold_st_d[i] = HOLD_FIRED;
          end
          default: begin
            hold_st_d[i] = HOLD_IDLE;
            presc_d[i]   = '0;
            cnt_d[i]     = '0;
          end
        endcase
      end
    end
  end

  // Long-press timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        hold_st_q[i] <= HOLD_IDLE;
        presc_q[i]   <= '0;
        cnt_q[i]     <= '0;
      end
      fire_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        hold_st_q[i] <= hold_st_d[i];
        presc_q[i]   <= presc_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      fire_q <= fire_d;
    end
  end

  assign btn_salud     = btn_q[SALUD];
  assign btn_energia   = btn_q[ENERGIA];
  assign btn_hambre    = btn_q[HAMBRE];
  assign btn_diversion = btn_q[DIVERSION];
  assign btn_reset     = fire_q[0];
  assign btn_test      = fire_q[1];
  assign count_reset   = cnt_q[0];
  assign count_test    = cnt_q[1];

endmodule

// File: tb/tb_tamagotchi_btn_conditioner.sv
// Scoreboard bench for tamagotchi_btn_conditioner. A reference model derives
// every output from the key history each clock and queues it; a monitor on
// the falling edge pops and compares. Directed phases add pulse-count checks.
module tb_tamagotchi_btn_conditioner;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 3;
  localparam int HOLD_S      = 5;
  localparam int REPEAT_MS   = 10;
  localparam int DEB         = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SEC         = CLK_HZ;
  localparam int REP         = CLK_HZ / 1000 * REPEAT_MS;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] key_n = '1;  // 0 salud,1 energia,2 hambre,3 diversion,4 reset,5 test
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
  logic [2:0] count_reset, count_test;

  tamagotchi_btn_conditioner #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_S(HOLD_S), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_salud_n    (key_n[0]),
    .key_energia_n  (key_n[1]),
    .key_hambre_n   (key_n[2]),
    .key_diversion_n(key_n[3]),
    .key_reset_n    (key_n[4]),
    .key_test_n     (key_n[5]),
    .btn_salud      (btn_salud),
    .btn_energia    (btn_energia),
    .btn_hambre     (btn_hambre),
    .btn_diversion  (btn_diversion),
    .btn_reset      (btn_reset),
    .btn_test       (btn_test),
    .count_reset    (count_reset),
    .count_test     (count_test)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] need;
    logic       br;
    logic       bt;
    logic [2:0] cr;
    logic [2:0] ct;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulse_cnt [6];
  int   rise_cyc  [6];

  // Reference model state: raw pressed history per key, debounced level, run lengths
  bit   hist [6][DEB+2];
  bit   deb  [6];
  int   run  [6];
  int   run_eff;

  function automatic int sat_secs(input int r);
    int s;
    s = (r - 1) / SEC;
    return (s > HOLD_S) ? HOLD_S : s;
  endfunction

  // Model: expected outputs after each rising edge, from values after the previous edge
  always @(posedge clk) begin
    obs_t e;
    bit   mask, flip;
    cyc++;
    e = '0;
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) begin
        deb[k] = 1'b0;
        run[k] = 0;
        for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b0;
      end
      run_eff = 0;
    end else begin
      mask = deb[4] | deb[5];
      for (int k = 0; k < 4; k++)
        e.need[k] = deb[k] && !mask &&
                    (AUTOREP ? ((run[k] - 1) % REP == 0) : (run[k] == 1));
      if (run[4] > 0) begin
        e.cr = 3'(sat_secs(run[4]));
        e.br = (run[4] - 1 == HOLD_S * SEC);
      end
      if (run_eff > 0) begin
        e.ct = 3'(sat_secs(run_eff));
        e.bt = (run_eff - 1 == HOLD_S * SEC);
      end
      for (int k = 0; k < 6; k++) begin
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[k][j] == deb[k]) flip = 1'b0;
        if (flip) deb[k] = !deb[k];
        for (int j = DEB + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = !key_n[k];
        run[k] = deb[k] ? run[k] + 1 : 0;
      end
      run_eff = (deb[5] && !deb[4]) ? run_eff + 1 : 0;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every cycle's outputs with the queued expectation
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      a = {btn_diversion, btn_hambre, btn_energia, btn_salud, btn_reset, btn_test,
           count_reset, count_test};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs@cycle%0d: got %h want %h", cyc, a, e);
      end
      for (int k = 0; k < 4; k++)
        if (a.need[k]) begin pulse_cnt[k]++; rise_cyc[k] = cyc; end
      if (a.br) begin pulse_cnt[4]++; rise_cyc[4] = cyc; end
      if (a.bt) begin pulse_cnt[5]++; rise_cyc[5] = cyc; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 6; k++) begin
      pulse_cnt[k] = 0;
      rise_cyc[k]  = -1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    clear_counts();
    step(3);
    check("reset_counts", {count_reset, count_test}, 0);
    rst_n = 1'b1;
    step(5);

    // Clean salud press: one pulse DEB+3 cycles after the edge, none on release
    clear_counts();
    t0 = cyc;
    key_n[0] = 1'b0;
    step(12);
    check("salud_pulses", pulse_cnt[0], 1);
    check("salud_latency", rise_cyc[0] - t0, DEB + 3);
    key_n[0] = 1'b1;
    step(12);
    check("salud_release", pulse_cnt[0], 1);

    // Hambre bounces every 2 cycles, then settles low
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      key_n[2] = ~key_n[2];
      step(2);
    end
    check("hambre_bounce", pulse_cnt[2], 0);
    key_n[2] = 1'b0;
    step(12);
    key_n[2] = 1'b1;
    step(10);
    check("hambre_pulses", pulse_cnt[2], 1);

    // Energia random short bounces, then settles low
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      key_n[1] = ~key_n[1];
      step($urandom_range(1, DEB - 1));
    end
    key_n[1] = 1'b0;
    step(12);
    key_n[1] = 1'b1;
    step(10);
    check("energia_pulses", pulse_cnt[1], 1);

    // Three need keys in the same cycle pulse together
    clear_counts();
    key_n[2:0] = 3'b000;
    step(12);
    key_n[2:0] = 3'b111;
    step(10);
    check("multi_salud", pulse_cnt[0], 1);
    check("multi_hambre", pulse_cnt[2], 1);
    check("multi_same_cycle", rise_cyc[1] - rise_cyc[0], 0);

    // Reset key long press
    clear_counts();
    key_n[4] = 1'b0;
    step(DEB + 3 + SEC + 1);
    check("reset_count_1s", count_reset, 1);
    step(5200 - (DEB + 3 + SEC + 1));
    check("reset_count_sat", count_reset, HOLD_S);
    check("reset_pulses", pulse_cnt[4], 1);
    key_n[4] = 1'b1;
    step(10);
    check("reset_count_clear", count_reset, 0);

    // Test key released before HOLD_S
    clear_counts();
    key_n[5] = 1'b0;
    step(3500);
    check("test_count_3", count_test, 3);
    key_n[5] = 1'b1;
    step(10);
    check("test_count_clear", count_test, 0);
    check("test_no_pulse", pulse_cnt[5], 0);

    // Reset key overrides test hold; salud masked meanwhile
    clear_counts();
    key_n[5] = 1'b0;
    step(2000);
    check("test_count_pre", count_test, 1);
    key_n[4] = 1'b0;
    step(20);
    check("test_forced_zero", count_test, 0);
    key_n[0] = 1'b0;
    step(30);
    key_n[0] = 1'b1;
    step(1500);
    key_n[5] = 1'b1;
    key_n[4] = 1'b1;
    step(20);
    check("masked_salud", pulse_cnt[0], 0);
    check("suppressed_test", pulse_cnt[5], 0);

    // Asynchronous reset in the middle of a hold
    clear_counts();
    key_n[4] = 1'b0;
    step(3200);
    check("hold_count_3", count_reset, 3);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
           count_reset, count_test}, 0);
    step(3);
    rst_n = 1'b1;
    step(20);
    check("rehold_count", count_reset, 0);
    key_n[4] = 1'b1;
    step(10);
    check("rehold_pulses", pulse_cnt[4], 0);

    // Held diversion key: one pulse, or three with auto-repeat
    clear_counts();
    key_n[3] = 1'b0;
    step(DEB + 3 + 2 * REP + 5);
    check("diversion_pulses", pulse_cnt[3], AUTOREP ? 3 : 1);
    key_n[3] = 1'b1;
    step(10);

    // Random activity on all keys, short holds only
    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 5);
      key_n[k] = ~key_n[k];
      step($urandom_range(1, 12));
    end
    key_n = '1;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
